// File: rtl/signal_pkg.sv
// Shared phase, light and flow encodings for the multi-approach signal controller.
package signal_pkg;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10,
        PH_PED    = 2'b11
    } phase_e;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;

    localparam logic [1:0] FLOW_NORMAL = 2'b00;
    localparam logic [1:0] FLOW_LOW    = 2'b01;
    localparam logic [1:0] FLOW_HIGH   = 2'b10;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/signal_tick_gen.sv
// Timing-tick prescaler: one registered tick every TICK_DIV clocks, restartable by clr.
module signal_tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          tick_r;

    // next prescaler count: restart on clear or after the last count
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr || (cnt_r == LAST)) begin
            cnt_nxt_s = {CW{1'b0}};
        end else begin
            cnt_nxt_s = cnt_r + CW'(1);
        end
    end

    // count register; tick is registered alongside so it tracks count == LAST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            tick_r <= (cnt_nxt_s == LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/signal_cu_multi.sv
// Round-robin intersection controller: green/yellow/all-red per approach with a
// latched pedestrian phase, flow-dependent green time and renderer valid pulses.
module signal_cu_multi
    import signal_pkg::*;
#(
    parameter int NUM_DIR      = 4,
    parameter int TICK_DIV     = 100_000_000,
    parameter int GREEN_NORMAL = 5,
    parameter int GREEN_LOW    = 3,
    parameter int GREEN_HIGH   = 8,
    parameter int YELLOW_T     = 2,
    parameter int ALLRED_T     = 1,
    parameter int PED_T        = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 traffic_sel,
    input  logic [NUM_DIR-1:0]         ped_req,
    output logic [$clog2(NUM_DIR)-1:0] o_dir,
    output logic [1:0]                 o_tr_state,
    output logic [2*NUM_DIR-1:0]       o_tr_light,
    output logic                       o_walk,
    output logic                       ped_ack,
    output logic                       tr_valid,
    output logic                       light_valid
);

    localparam int DW      = $clog2(NUM_DIR);
    localparam int LW      = 2 * NUM_DIR;
    localparam int MAX_DUR = max2(max2(max2(GREEN_NORMAL, GREEN_LOW), max2(GREEN_HIGH, YELLOW_T)),
                                  max2(ALLRED_T, PED_T));
    localparam int TW      = $clog2(MAX_DUR + 1);

    phase_e          state_r;
    phase_e          state_nxt_s;
    logic [DW-1:0]   dir_r;
    logic [DW-1:0]   dir_nxt_s;
    logic [DW-1:0]   dir_inc_s;
    logic [TW-1:0]   timer_r;
    logic [TW-1:0]   dur_s;
    logic [TW-1:0]   green_dur_r;
    logic [TW-1:0]   green_sel_s;
    logic            tick_s;
    logic            phase_done_s;
    logic            ped_exit_s;
    logic            first_r;
    logic            boot_r;
    logic [NUM_DIR-1:0] pend_r;
    logic [NUM_DIR-1:0] pend_nxt_s;
    logic [NUM_DIR-1:0] ped_hold_r;
    logic [NUM_DIR-1:0] ped_hold_nxt_s;
    logic [LW-1:0]   light_r;
    logic [LW-1:0]   light_nxt_s;
    logic            walk_r;
    logic            ack_r;
    logic            tr_valid_r;
    logic            light_valid_r;

    function automatic logic [LW-1:0] light_vec(input phase_e ph, input logic [DW-1:0] d);
        logic [LW-1:0] v;
        v = {LW{1'b0}};
        for (int i = 0; i < NUM_DIR; i++) begin
            if (DW'(i) == d) begin
                case (ph)
                    PH_GREEN:  v[2*i +: 2] = LIGHT_GREEN;
                    PH_YELLOW: v[2*i +: 2] = LIGHT_YELLOW;
                    default:   v[2*i +: 2] = LIGHT_RED;
                endcase
            end
        end
        return v;
    endfunction

    signal_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (reset),
        .clr   (phase_done_s),
        .tick  (tick_s)
    );

    // green length candidate and current phase length
    always_comb begin
        green_sel_s = TW'(GREEN_NORMAL);
        dur_s       = TW'(ALLRED_T);
        case (traffic_sel)
            FLOW_LOW:  green_sel_s = TW'(GREEN_LOW);
            FLOW_HIGH: green_sel_s = TW'(GREEN_HIGH);
            default:   green_sel_s = TW'(GREEN_NORMAL);
        endcase
        case (state_r)
            PH_GREEN:  dur_s = green_dur_r;
            PH_YELLOW: dur_s = TW'(YELLOW_T);
            PH_ALLRED: dur_s = TW'(ALLRED_T);
            PH_PED:    dur_s = TW'(PED_T);
            default:   dur_s = TW'(ALLRED_T);
        endcase
    end

    assign phase_done_s = tick_s && (timer_r == (dur_s - TW'(1)));
    assign ped_exit_s   = phase_done_s && (state_r == PH_PED);
    assign dir_inc_s    = (dir_r == DW'(NUM_DIR - 1)) ? {DW{1'b0}} : (dir_r + DW'(1));

    // phase sequencing; the first green after reset keeps approach 0
    always_comb begin
        state_nxt_s = state_r;
        dir_nxt_s   = dir_r;
        if (phase_done_s) begin
            case (state_r)
                PH_GREEN:  state_nxt_s = PH_YELLOW;
                PH_YELLOW: state_nxt_s = PH_ALLRED;
                PH_ALLRED: begin
                    if (|pend_r) begin
                        state_nxt_s = PH_PED;
                    end else begin
                        state_nxt_s = PH_GREEN;
                        dir_nxt_s   = first_r ? dir_r : dir_inc_s;
                    end
                end
                PH_PED: begin
                    state_nxt_s = PH_GREEN;
                    dir_nxt_s   = first_r ? dir_r : dir_inc_s;
                end
                default:   state_nxt_s = PH_ALLRED;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // pending requests: cleared on walk exit except requests that arrived during the walk
    always_comb begin
        pend_nxt_s     = pend_r | ped_req;
        ped_hold_nxt_s = {NUM_DIR{1'b0}};
        if (ped_exit_s) begin
            pend_nxt_s = ped_hold_r | ped_req;
        end else begin
            pend_nxt_s = pend_r | ped_req;
        end
        if ((state_r == PH_PED) && !ped_exit_s) begin
            ped_hold_nxt_s = ped_hold_r | ped_req;
        end else begin
            ped_hold_nxt_s = {NUM_DIR{1'b0}};
        end
        light_nxt_s = light_vec(state_nxt_s, dir_nxt_s);
    end

    // FSM state, phase timer, latched green length and request registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= PH_ALLRED;
            dir_r       <= {DW{1'b0}};
            timer_r     <= {TW{1'b0}};
            green_dur_r <= TW'(GREEN_NORMAL);
            first_r     <= 1'b1;
            pend_r      <= {NUM_DIR{1'b0}};
            ped_hold_r  <= {NUM_DIR{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            dir_r      <= dir_nxt_s;
            pend_r     <= pend_nxt_s;
            ped_hold_r <= ped_hold_nxt_s;
            if (phase_done_s) begin
                timer_r <= {TW{1'b0}};
            end else if (tick_s) begin
                timer_r <= timer_r + TW'(1);
            end
            if (phase_done_s && (state_nxt_s == PH_GREEN)) begin
                green_dur_r <= green_sel_s;
                first_r     <= 1'b0;
            end
        end
    end

    // output registers; boot_r produces the tr_valid pulse for the post-reset ALLRED
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            boot_r        <= 1'b1;
            light_r       <= {LW{1'b0}};
            walk_r        <= 1'b0;
            ack_r         <= 1'b0;
            tr_valid_r    <= 1'b0;
            light_valid_r <= 1'b0;
        end else begin
            boot_r        <= 1'b0;
            light_r       <= light_nxt_s;
            walk_r        <= (state_nxt_s == PH_PED);
            ack_r         <= ped_exit_s;
            tr_valid_r    <= phase_done_s | boot_r;
            light_valid_r <= (light_nxt_s != light_r);
        end
    end

    assign o_dir       = dir_r;
    assign o_tr_state  = state_r;
    assign o_tr_light  = light_r;
    assign o_walk      = walk_r;
    assign ped_ack     = ack_r;
    assign tr_valid    = tr_valid_r;
    assign light_valid = light_valid_r;

endmodule

// File: tb/tb_signal_cu_multi.sv
// Directed bench for signal_cu_multi: 4 approaches, 4-clock tick, durations 5/3/8/2/1/4.
module tb_signal_cu_multi;

    logic       clk;
    logic       reset;
    logic [1:0] traffic_sel;
    logic [3:0] ped_req;
    logic [1:0] o_dir;
    logic [1:0] o_tr_state;
    logic [7:0] o_tr_light;
    logic       o_walk;
    logic       ped_ack;
    logic       tr_valid;
    logic       light_valid;

    int n_vec = 0;
    int n_err = 0;

    signal_cu_multi #(
        .NUM_DIR      (4),
        .TICK_DIV     (4),
        .GREEN_NORMAL (5),
        .GREEN_LOW    (3),
        .GREEN_HIGH   (8),
        .YELLOW_T     (2),
        .ALLRED_T     (1),
        .PED_T        (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .traffic_sel (traffic_sel),
        .ped_req     (ped_req),
        .o_dir       (o_dir),
        .o_tr_state  (o_tr_state),
        .o_tr_light  (o_tr_light),
        .o_walk      (o_walk),
        .ped_ack     (ped_ack),
        .tr_valid    (tr_valid),
        .light_valid (light_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on the first cycle of a phase; leaves the bench on the first cycle of the next one.
    task automatic phase(input string tag, input logic [1:0] st, input logic [1:0] d, input int len,
                         input logic [7:0] lt, input logic lv, input int mid_sel, input logic [3:0] mid_ped);
        int half;
        half = len / 2;
        chk({tag, ".state"}, 32'(o_tr_state), 32'(st));
        chk({tag, ".dir"},   32'(o_dir),      32'(d));
        chk({tag, ".light"}, 32'(o_tr_light), 32'(lt));
        chk({tag, ".trv"},   32'(tr_valid),   32'd1);
        chk({tag, ".lv"},    32'(light_valid), 32'(lv));
        chk({tag, ".walk"},  32'(o_walk),     32'd0);
        step(half);
        if (mid_sel >= 0) traffic_sel = 2'(mid_sel);
        ped_req = mid_ped;
        step(1);
        ped_req = 4'b0000;
        step(len - half - 2);
        chk({tag, ".last_state"}, 32'(o_tr_state), 32'(st));
        chk({tag, ".last_trv"},   32'(tr_valid),   32'd0);
        chk({tag, ".last_ack"},   32'(ped_ack),    32'd0);
        step(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        traffic_sel = 2'b00;
        ped_req     = 4'b0000;
        step(1);
        chk("rst.state", 32'(o_tr_state), 32'd2);
        chk("rst.dir",   32'(o_dir),      32'd0);
        chk("rst.light", 32'(o_tr_light), 32'h00);
        chk("rst.walk",  32'(o_walk),     32'd0);
        chk("rst.ack",   32'(ped_ack),    32'd0);
        chk("rst.trv",   32'(tr_valid),   32'd0);
        chk("rst.lv",    32'(light_valid), 32'd0);
        reset = 1'b1;
        step(1);
        chk("boot.trv",   32'(tr_valid),   32'd1);
        chk("boot.state", 32'(o_tr_state), 32'd2);
        step(3);

        // normal flow, then low flow selected mid-green of dir1
        phase("g0a", 2'd0, 2'd0, 20, 8'h02, 1'b1, -1, 4'b0000);
        phase("y0a", 2'd1, 2'd0,  8, 8'h01, 1'b1, -1, 4'b0000);
        phase("a0a", 2'd2, 2'd0,  4, 8'h00, 1'b1, -1, 4'b0000);
        phase("g1a", 2'd0, 2'd1, 20, 8'h08, 1'b1,  1, 4'b0000);
        phase("y1a", 2'd1, 2'd1,  8, 8'h04, 1'b1, -1, 4'b0000);
        phase("a1a", 2'd2, 2'd1,  4, 8'h00, 1'b1, -1, 4'b0000);
        phase("g2a", 2'd0, 2'd2, 12, 8'h20, 1'b1, -1, 4'b0000);
        phase("y2a", 2'd1, 2'd2,  8, 8'h10, 1'b1, -1, 4'b0000);
        phase("a2a", 2'd2, 2'd2,  4, 8'h00, 1'b1, -1, 4'b0000);
        phase("g3a", 2'd0, 2'd3, 12, 8'h80, 1'b1,  2, 4'b0000);
        phase("y3a", 2'd1, 2'd3,  8, 8'h40, 1'b1, -1, 4'b0000);
        phase("a3a", 2'd2, 2'd3,  4, 8'h00, 1'b1, -1, 4'b0000);
        phase("g0b", 2'd0, 2'd0, 32, 8'h02, 1'b1,  0, 4'b0000);
        phase("y0b", 2'd1, 2'd0,  8, 8'h01, 1'b1, -1, 4'b0000);
        phase("a0b", 2'd2, 2'd0,  4, 8'h00, 1'b1, -1, 4'b0000);
        phase("g1b", 2'd0, 2'd1, 20, 8'h08, 1'b1, -1, 4'b0100);
        phase("y1b", 2'd1, 2'd1,  8, 8'h04, 1'b1, -1, 4'b0000);
        phase("a1b", 2'd2, 2'd1,  4, 8'h00, 1'b1, -1, 4'b0000);

        // walk phase; a request in its last cycle must survive the clear
        chk("ped1.state", 32'(o_tr_state), 32'd3);
        chk("ped1.dir",   32'(o_dir),      32'd1);
        chk("ped1.light", 32'(o_tr_light), 32'h00);
        chk("ped1.walk",  32'(o_walk),     32'd1);
        chk("ped1.trv",   32'(tr_valid),   32'd1);
        chk("ped1.lv",    32'(light_valid), 32'd0);
        step(15);
        chk("ped1.last_state", 32'(o_tr_state), 32'd3);
        chk("ped1.last_walk",  32'(o_walk),     32'd1);
        ped_req = 4'b0001;
        step(1);
        ped_req = 4'b0000;
        chk("ped1.ack", 32'(ped_ack), 32'd1);
        phase("g2b", 2'd0, 2'd2, 20, 8'h20, 1'b1, -1, 4'b0000);
        phase("y2b", 2'd1, 2'd2,  8, 8'h10, 1'b1, -1, 4'b0000);
        phase("a2b", 2'd2, 2'd2,  4, 8'h00, 1'b1, -1, 4'b0000);
        chk("ped2.state", 32'(o_tr_state), 32'd3);
        chk("ped2.walk",  32'(o_walk),     32'd1);
        chk("ped2.lv",    32'(light_valid), 32'd0);
        step(16);
        chk("ped2.ack", 32'(ped_ack), 32'd1);
        phase("g3b", 2'd0, 2'd3, 20, 8'h80, 1'b1, -1, 4'b0000);

        // asynchronous reset mid-yellow with a request pending
        chk("y3r.state", 32'(o_tr_state), 32'd1);
        step(2);
        ped_req = 4'b0010;
        step(1);
        ped_req = 4'b0000;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst.state", 32'(o_tr_state), 32'd2);
        chk("arst.dir",   32'(o_dir),      32'd0);
        chk("arst.light", 32'(o_tr_light), 32'h00);
        chk("arst.walk",  32'(o_walk),     32'd0);
        chk("arst.trv",   32'(tr_valid),   32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(1);
        chk("reboot.trv", 32'(tr_valid), 32'd1);
        step(3);
        chk("reboot.state", 32'(o_tr_state), 32'd0);
        chk("reboot.dir",   32'(o_dir),      32'd0);
        chk("reboot.light", 32'(o_tr_light), 32'h02);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/signal_cu_multi.md
Name: signal_cu_multi

Overview:
Parametrised successor to the single-approach Signal_CU. Runs an intersection of NUM_DIR approaches in round-robin, with flow-dependent green time, yellow and all-red clearance, and a latched pedestrian-request phase. Sits between the traffic-flow selector and the VGA road renderer, which consumes the light vector and the valid pulses.

Parameters:
NUM_DIR, 4, number of approaches (2..8)
TICK_DIV, 100_000_000, clocks per timing tick (>=2)
GREEN_NORMAL, 5, green ticks when traffic_sel=00 (or reserved 11)
GREEN_LOW, 3, green ticks when traffic_sel=01
GREEN_HIGH, 8, green ticks when traffic_sel=10
YELLOW_T, 2, yellow ticks
ALLRED_T, 1, all-red clearance ticks
PED_T, 4, pedestrian walk ticks
All durations are >=1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
traffic_sel  in  2  flow level: 00 normal, 01 low, 10 high, 11 reserved (treated as normal)
ped_req  in  NUM_DIR  pedestrian button per approach; level or pulse, sampled every clk
o_dir  out  $clog2(NUM_DIR)  approach currently served
o_tr_state  out  2  phase: 00 GREEN, 01 YELLOW, 10 ALLRED, 11 PED
o_tr_light  out  2*NUM_DIR  per-approach light, approach i at bits [2i+1:2i]: 00 RED, 01 YELLOW, 10 GREEN
o_walk  out  1  pedestrian walk lamp; high only in PED
ped_ack  out  1  one-clk pulse on PED exit
tr_valid  out  1  one-clk pulse on the first cycle of every new phase
light_valid  out  1  one-clk pulse on the first cycle o_tr_light differs from its previous value

Behaviour:
- Reset (reset=0, async) values:
  - o_tr_state=ALLRED, o_dir=0, all lights RED.
  - o_walk=0, ped_ack=0, tr_valid=0, light_valid=0.
  - Prescaler=0, phase timer=0, ped_pending=0.
- After reset deasserts, the block starts in ALLRED with a full ALLRED_T duration.
- Tick: the prescaler counts 0..TICK_DIV-1, and tick=1 when count=TICK_DIV-1.
  - Prescaler and phase timer clear on every phase change.
  - A phase of D ticks therefore lasts exactly D*TICK_DIV clocks.
- Phase timer counts ticks. The phase changes on the clock edge where the D-th tick occurs. Timer width is $clog2(max duration+1).
- Transitions:
  - GREEN -> YELLOW after the latched green duration.
  - YELLOW -> ALLRED after YELLOW_T.
  - ALLRED -> PED if ped_pending is nonzero, else -> GREEN with o_dir advanced by 1. o_dir wraps NUM_DIR-1 -> 0.
  - PED -> GREEN for the next o_dir. The rotation pointer advances in this case too.
  - The first ALLRED after reset goes to GREEN with o_dir=0 (no advance).
- Green duration is selected from traffic_sel as sampled on the ALLRED/PED->GREEN edge. traffic_sel changes mid-phase do not affect the current green.
- Lights:
  - GREEN: approach o_dir is GREEN, all others RED.
  - YELLOW: approach o_dir is YELLOW, all others RED.
  - ALLRED and PED: all approaches RED.
  - Lights are registered and change in the same cycle as o_tr_state.
- Pedestrian requests:
  - ped_pending |= ped_req every clk.
  - ped_pending clears on PED exit, the same cycle as ped_ack. A ped_req bit asserted in that cycle survives (set wins over clear).
  - Requests arriving during PED are held for the next cycle of the rotation.
- tr_valid pulses on every phase entry, including the ALLRED entry right after reset.
- light_valid pulses only when the vector actually changes. It does not pulse on the ALLRED->PED edge.
- Reset mid-phase returns immediately to the reset values and discards pending requests.

Decomposition:
- Package signal_pkg holds:
  - phase_e enum (GREEN, YELLOW, ALLRED, PED)
  - light encoding constants (RED, YELLOW, GREEN)
  - flow encoding constants (FLOW_NORMAL, FLOW_LOW, FLOW_HIGH)
- One sub-module, signal_tick_gen: parametrised TICK_DIV prescaler with a synchronous clear input and a tick output.
- The FSM, timer, pending register and output registers stay in signal_cu_multi.

Test Plan:
All scenarios use NUM_DIR=4, TICK_DIV=4, durations 5/3/8/2/1/4.
- Reset release, traffic_sel=00:
  - ALLRED for 4 clks, then GREEN dir0 for 20 clks, YELLOW for 8, ALLRED for 4, then GREEN dir1.
  - tr_valid pulses at each edge.
  - o_tr_light during GREEN dir0 = 8'b00_00_00_10.
- traffic_sel=01 held:
  - Every green lasts 12 clks.
  - Switching to 10 mid-green keeps the current green at 12; the next green lasts 32.
- Rotation wrap: run 4 full cycles; o_dir sequence is 0,1,2,3,0.
- ped_req[2] pulsed 1 clk during GREEN dir1:
  - After the following ALLRED, PED for 16 clks with o_walk=1 and all lights RED.
  - light_valid does not pulse on PED entry.
  - ped_ack pulses on exit, then GREEN dir2.
- ped_req asserted exactly in the ped_ack cycle: the pending bit stays set, and the next ALLRED enters PED again.
- Reset asserted mid-YELLOW, asynchronously between clock edges: outputs reach reset values before the next clk edge, and pending is cleared.
